// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the gray-pointer FIFO: pointer width and the
// bin/gray conversions used by both the read- and write-side controllers.
package fifo_ptr_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Conversions work on a 32-bit container; callers zero-extend and truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync_chain.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into this clock;
// synchronous active-low reset clears every stage.
module ptr_sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // ASYNC_REG lets CDC tools and placers treat the chain as a synchronizer.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller of the gray-pointer FIFO: syncs the write
// pointer, tracks read pointers, empty and level. Optional macro FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic                  rd_req,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_level
`ifdef FIFO_RD_UNDERFLOW_EN
  ,
  output logic                  underflow
`endif
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0] wr_gray_s;
  logic [PTR_W-1:0] wr_bin_s;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_nxt;

  ptr_sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wr_ptr_gray),
    .q     (wr_gray_s)
  );

  assign wr_bin_s   = PTR_W'(gray2bin(32'(wr_gray_s)));
  assign rd_en      = rd_req & ~empty;
  assign rd_bin_nxt = rd_bin + PTR_W'(rd_en);
  assign rd_addr    = rd_bin[ADDR_WIDTH-1:0];

  // Empty and level look one read ahead so they already account for this cycle's read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      rd_level    <= '0;
    end else begin
      rd_bin      <= rd_bin_nxt;
      rd_ptr_gray <= PTR_W'(bin2gray(32'(rd_bin_nxt)));
      empty       <= (PTR_W'(bin2gray(32'(rd_bin_nxt))) == wr_gray_s);
      rd_level    <= wr_bin_s - rd_bin_nxt;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  // Sticky until reset so software can detect any read attempted on an empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (rd_req && empty) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Scoreboard bench for fifo_rd_ptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2); also
// checks underflow when FIFO_RD_UNDERFLOW_EN is defined.
module tb_fifo_rd_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wr_ptr_gray;
  logic       rd_req;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic [4:0] rd_level;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  fifo_rd_ptr_ctrl #(
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_req      (rd_req),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_level    (rd_level)
`ifdef FIFO_RD_UNDERFLOW_EN
    ,
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are held across one rising edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic rn, input logic [4:0] wg, input logic rr);
    rst_n       = rn;
    wr_ptr_gray = wg;
    rd_req      = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input logic e, input logic [4:0] lvl,
                            input logic [4:0] gray, input logic [3:0] addr);
    checkOutput("empty", 32'(empty), 32'(e));
    checkOutput("rd_level", 32'(rd_level), 32'(lvl));
    checkOutput("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray));
    checkOutput("rd_addr", 32'(rd_addr), 32'(addr));
  endtask

  // Monitor: every accepted read must match the next expected RAM address.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rd_en: got rd_addr %0h expected no read at %0t", rd_addr, $time);
        end else begin
          checkOutput("rd_addr_on_rd_en", 32'(rd_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish within 100000ns");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with a nonzero write pointer on the input
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b01100, 1'b0);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);
`ifdef FIFO_RD_UNDERFLOW_EN
    checkOutput("underflow_reset", 32'(underflow), 32'd0);
`endif
    applyStimulus(1'b0, 5'b00000, 1'b0);
    applyStimulus(1'b1, 5'b00000, 1'b0);
    applyStimulus(1'b1, 5'b00000, 1'b0);

    // Single entry: visible two edges after the pointer change
    applyStimulus(1'b1, 5'b00001, 1'b0);
    checkOutput("single_empty_n", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b00001, 1'b0);
    checkOutput("single_empty_n1", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b00001, 1'b0);
    checkOutput("single_empty_n2", 32'(empty), 32'd0);
    checkOutput("single_level_n2", 32'(rd_level), 32'd1);
    exp_q.push_back(4'd0);
    applyStimulus(1'b1, 5'b00001, 1'b1);
    checkState(1'b1, 5'd0, 5'b00001, 4'd1);
    applyStimulus(1'b1, 5'b00001, 1'b0);

    // Re-reset so the drain starts from pointer zero
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00000, 1'b0);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);

    // Full drain: sixteen entries read back to back
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'b11000, 1'b0);
    checkState(1'b0, 5'd16, 5'b00000, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(4'(k - 1));
      applyStimulus(1'b1, 5'b11000, 1'b1);
      checkOutput("drain_level", 32'(rd_level), 32'(16 - k));
      checkOutput("drain_empty", 32'(empty), 32'(k == 16));
    end
    checkState(1'b1, 5'd0, 5'b11000, 4'd0);

    // Wrap: write to bin 31, drain, then write to bin 0 and read across the wrap
    applyStimulus(1'b1, 5'b10000, 1'b0);
    checkOutput("wrap_hold_empty_a", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b10000, 1'b0);
    checkOutput("wrap_hold_empty_b", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b10000, 1'b0);
    checkOutput("wrap_level15", 32'(rd_level), 32'd15);
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(4'(k - 1));
      applyStimulus(1'b1, 5'b10000, 1'b1);
      checkOutput("wrap_level", 32'(rd_level), 32'(15 - k));
      checkOutput("wrap_empty", 32'(empty), 32'(k == 15));
    end
    checkState(1'b1, 5'd0, 5'b10000, 4'd15);
    applyStimulus(1'b1, 5'b00000, 1'b0);
    checkOutput("wrap_no_spurious_a", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b00000, 1'b0);
    checkOutput("wrap_no_spurious_b", 32'(empty), 32'd1);
    applyStimulus(1'b1, 5'b00000, 1'b0);
    checkState(1'b0, 5'd1, 5'b10000, 4'd15);
    exp_q.push_back(4'd15);
    applyStimulus(1'b1, 5'b00000, 1'b1);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);

    // Underflow attempts: requests while empty are ignored
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'b00000, 1'b1);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);
    applyStimulus(1'b1, 5'b00000, 1'b0);
`ifdef FIFO_RD_UNDERFLOW_EN
    checkOutput("underflow_sticky", 32'(underflow), 32'd1);
`endif

    // Mid-run reset with level 7, then re-synchronization
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'b00100, 1'b0);
    checkState(1'b0, 5'd7, 5'b00000, 4'd0);
    applyStimulus(1'b0, 5'b00100, 1'b0);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);
`ifdef FIFO_RD_UNDERFLOW_EN
    checkOutput("underflow_cleared", 32'(underflow), 32'd0);
`endif
    applyStimulus(1'b1, 5'b00100, 1'b0);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);
    applyStimulus(1'b1, 5'b00100, 1'b0);
    checkState(1'b1, 5'd0, 5'b00000, 4'd0);
    applyStimulus(1'b1, 5'b00100, 1'b0);
    checkState(1'b0, 5'd7, 5'b00000, 4'd0);

    applyStimulus(1'b1, 5'b00100, 1'b0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
# fifo_rd_ptr_ctrl

Read-side pointer controller for the gray-pointer FIFO used between the 8051 core and its peripheral clock domains. It synchronizes the write domain's gray-coded write pointer into the read clock and converts it to binary. It maintains the binary and gray read pointers and produces `empty`, the occupancy level and the RAM read address. It is the consumer end of the pointers produced by the write side's bin-to-gray conversion.

## Interface
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- `SYNC_STAGES`, default 2: number of synchronizer flops on the incoming write pointer. Minimum 2.
- `clk` in, 1: read-domain clock. This is the only clock.
- `rst_n` in, 1: reset. Synchronous, active-low.
- `wr_ptr_gray` in, ADDR_WIDTH+1: gray write pointer from the write domain. It is asynchronous to `clk`.
- `rd_req` in, 1: consumer read request.
- `rd_en` out, 1: read accepted this cycle. Drives the RAM read enable.
- `rd_addr` out, ADDR_WIDTH: RAM read address, equal to `rd_bin[ADDR_WIDTH-1:0]`.
- `rd_ptr_gray` out, ADDR_WIDTH+1: registered gray read pointer, sent to the write domain.
- `empty` out, 1: FIFO empty, registered.
- `rd_level` out, ADDR_WIDTH+1: registered occupancy, range 0..2^ADDR_WIDTH.
- `underflow` out, 1: present only under `FIFO_RD_UNDERFLOW_EN`.

## Operation
- **Synchronizer:** `wr_ptr_gray` enters a chain of SYNC_STAGES flops. The last stage is `wr_gray_s`. `wr_bin_s = gray2bin(wr_gray_s)`, combinational.
- **Read accept:** `rd_en = rd_req & ~empty`. It depends only on the registered `empty`.
- **Next pointer:** `rd_bin_nxt = rd_bin + rd_en`, modulo 2^(ADDR_WIDTH+1).
  - Wrap from all-ones to 0 is natural. The MSB toggles once per pass through the FIFO.
- **Per-cycle register updates:**
  - `rd_bin <= rd_bin_nxt`
  - `rd_ptr_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1)`
  - `empty <= (bin2gray(rd_bin_nxt) == wr_gray_s)`
  - `rd_level <= wr_bin_s - rd_bin_nxt`, modulo 2^(ADDR_WIDTH+1). The result never exceeds 2^ADDR_WIDTH.
- **Simultaneous read and write arrival:** the read consumes the old state. `empty` and `rd_level` reflect both events on the next edge.
- **Requests while empty:** `rd_req` while `empty`=1 is ignored. The pointers hold.
- There is no state machine. The only state is the pointer register set plus the synchronizer chain.

## Timing
- **Reset values:** everything below holds at the first edge with `rst_n`=0.
  - All sync stages = 0
  - `rd_bin` = 0, `rd_ptr_gray` = 0, `rd_addr` = 0
  - `empty` = 1, `rd_level` = 0, `rd_en` = 0
  - `underflow` = 0
- **Write-to-empty latency:** a `wr_ptr_gray` change stable before edge N appears in `empty`/`rd_level` after edge N+SYNC_STAGES. That is 3 cycles with the defaults.
- **Read latency:** the RAM samples `rd_addr` on the cycle `rd_en`=1. `rd_addr`, `rd_ptr_gray`, `empty` and `rd_level` update on the following edge. Back-to-back reads are sustained at one per cycle until empty.
- **Reset mid-operation:** reset takes effect at the next edge and clears the synchronizer. The write domain must be reset in the same window.
- **Pointer encoding:** `rd_ptr_gray` changes by exactly one bit per accepted read. It is glitch-free because it is a register output.

## Configuration
- **`FIFO_RD_UNDERFLOW_EN` defined:**
  - Adds the `underflow` output port.
  - `underflow` is a sticky flag set on any edge with `rd_req`=1 and `empty`=1.
  - It clears only on reset.
- **`FIFO_RD_UNDERFLOW_EN` undefined:** the port and the flop are absent. Behaviour is otherwise identical.

## Structure
- **Package `fifo_ptr_pkg`:**
  - `PTR_W = ADDR_WIDTH+1` helper.
  - `bin2gray` and `gray2bin` functions, shared with the write-side controller.
  - Default `SYNC_STAGES` constant.
- **Sub-module `ptr_sync_chain`:** a parameterized width × SYNC_STAGES flop chain with synchronous active-low reset. It carries the synchronizer attributes for CDC checking.

## Test plan
All scenarios use ADDR_WIDTH=4 and SYNC_STAGES=2.
- **Reset:** `rst_n`=0 for 3 cycles with `wr_ptr_gray`=5'b01100 -> `empty`=1, `rd_level`=0, `rd_addr`=0, `rd_ptr_gray`=0.
- **Single entry:** `wr_ptr_gray` 0->5'b00001 at edge N -> `empty`=0 and `rd_level`=1 after edge N+2. Then `rd_req`=1 -> one `rd_en` pulse at `rd_addr`=0, then `rd_ptr_gray`=5'b00001, `empty`=1, `rd_level`=0.
- **Full drain:** `wr_ptr_gray`=5'b11000 (bin 16) -> `rd_level`=16. Hold `rd_req` -> 16 consecutive `rd_en` with `rd_addr` 0..15, then `empty`=1 and `rd_ptr_gray`=5'b11000.
- **Wrap:** advance the write pointer to bin 31 and then bin 0, reading continuously -> `rd_bin` wraps 31->0, `rd_ptr_gray` goes 5'b10000->5'b00000, `rd_level` is correct throughout, and no spurious `empty` deassert occurs.
- **Underflow:** `rd_req`=1 while `empty` -> `rd_en`=0 and the pointers hold. With `FIFO_RD_UNDERFLOW_EN`, `underflow`=1 and stays set until reset.
- **Mid-run reset:** `rd_level`=7, then `rst_n`=0 for one cycle -> all outputs take their reset values at that edge and stay there until the write pointer is re-synchronized.
